// File: rtl/rv32i_types.sv
// Shared RV32I types: word width, load/store width codes and the data-memory port state.
package rv32i_types;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: shift the cache word down to the addressed byte/half
// and sign- or zero-extend according to the load width code.
module load_align
  import rv32i_types::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (load_funct3_t'(funct3))
      lb:      data = {{(XLEN - 8){shifted[7]}}, shifted[7:0]};
      lbu:     data = {{(XLEN - 8){1'b0}}, shifted[7:0]};
      lh:      data = {{(XLEN - 16){shifted[15]}}, shifted[15:0]};
      lhu:     data = {{(XLEN - 16){1'b0}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// Memory-stage data-memory port: issues cache requests from EX/MEM, stalls until the
// response, and returns extended load data, holding it while the pipeline is frozen.
module dmem_access
  import rv32i_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] mar,
  input  logic [XLEN-1:0] wdata,
  input  logic            pipe_hold,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_resp,
  output logic [XLEN-1:0] dmem_address,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic [3:0]      dmem_wmask,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            mem_stall,
  output logic [XLEN-1:0] load_data
);

  dmem_state_t     state;
  dmem_state_t     state_nx;
  logic            op;
  logic            active;
  logic            resp_v;
  logic [3:0]      mask_base;
  logic [XLEN-1:0] load_live;
  logic [XLEN-1:0] load_q;

  // DONE never re-requests, so a store held by pipe_hold is written only once.
  assign op     = mem_read | mem_write;
  assign active = rst & (state != DONE);
  assign resp_v = active & op & dmem_resp;

  load_align u_load_align (
    .funct3 (funct3),
    .offset (mar[1:0]),
    .rdata  (dmem_rdata),
    .data   (load_live)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (resp_v)  state_nx = pipe_hold ? DONE : IDLE;
        else if (op) state_nx = BUSY;
      end
      BUSY: begin
        if (resp_v) state_nx = pipe_hold ? DONE : IDLE;
      end
      DONE: begin
        if (!pipe_hold) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      load_q <= '0;
    end else begin
      state <= state_nx;
      if (resp_v) load_q <= load_live;
    end
  end

  // Store byte enables before alignment to the address offset.
  always_comb begin
    mask_base = 4'b0000;
    case (store_funct3_t'(funct3))
      sb:      mask_base = 4'b0001;
      sh:      mask_base = 4'b0011;
      sw:      mask_base = 4'b1111;
      default: mask_base = 4'b0000;
    endcase
  end

  assign dmem_address = {mar[XLEN-1:2], 2'b00};
  assign dmem_wdata   = wdata;
  assign dmem_read    = active & mem_read;
  assign dmem_write   = active & mem_write;
  assign mem_stall    = active & op & ~dmem_resp;
  assign dmem_wmask   = rst ? 4'(mask_base << mar[1:0]) : 4'b0000;
  assign load_data    = resp_v ? load_live : load_q;

endmodule

// File: tb/tb_dmem_access.sv
// Directed self-checking bench for dmem_access: hits, multi-cycle misses, held
// completions, write masks and reset abandonment.
module tb_dmem_access;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] mar;
  logic [31:0] wdata;
  logic        pipe_hold;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        mem_stall;
  logic [31:0] load_data;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int wcount = 0;

  dmem_access dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .mar          (mar),
    .wdata        (wdata),
    .pipe_hold    (pipe_hold),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .mem_stall    (mem_stall),
    .load_data    (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic hold,
                       input logic resp, input logic [31:0] rdat);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    mar        = a;
    wdata      = wd;
    pipe_hold  = hold;
    dmem_resp  = resp;
    dmem_rdata = rdat;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0);
    tick();
    tick();
    chk("rst_read", 32'(dmem_read), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_wmask", 32'(dmem_wmask), 32'h0);
    chk("rst_load", load_data, 32'h0);
    rst = 1'b1;

    // lw hit in the issue cycle
    tick();
    drive(1, 0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
    chk("lw_addr", dmem_address, 32'h100);
    chk("lw_read", 32'(dmem_read), 32'h1);
    chk("lw_stall", 32'(mem_stall), 32'h0);
    chk("lw_load", load_data, 32'hDEADBEEF);
    tick();
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0);
    chk("lw_loadq", load_data, 32'hDEADBEEF);
    chk("idle_stall", 32'(mem_stall), 32'h0);

    // lb with 3-cycle miss
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h0);
      chk("lb_stall", 32'(mem_stall), 32'h1);
      chk("lb_read", 32'(dmem_read), 32'h1);
      chk("lb_addr", dmem_address, 32'h200);
      tick();
    end
    drive(1, 0, 3'b000, 32'h203, 32'h0, 0, 1, 32'h80112233);
    chk("lb_resp_stall", 32'(mem_stall), 32'h0);
    chk("lb_load", load_data, 32'hFFFFFF80);
    tick();

    // lbu back-to-back, same stimulus
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 3'b100, 32'h203, 32'h0, 0, 0, 32'h0);
      chk("lbu_stall", 32'(mem_stall), 32'h1);
      chk("lbu_read", 32'(dmem_read), 32'h1);
      tick();
    end
    drive(1, 0, 3'b100, 32'h203, 32'h0, 0, 1, 32'h80112233);
    chk("lbu_load", load_data, 32'h00000080);
    tick();

    // lh / lhu at offset 2 with hit
    drive(1, 0, 3'b001, 32'h402, 32'h0, 0, 1, 32'h9ABC1234);
    chk("lh_load", load_data, 32'hFFFF9ABC);
    tick();
    drive(1, 0, 3'b101, 32'h402, 32'h0, 0, 1, 32'h9ABC1234);
    chk("lhu_load", load_data, 32'h00009ABC);
    tick();

    // sh at offset 2, response after 2 cycles
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 3'b001, 32'h42, 32'hABCD0000, 0, 0, 32'h0);
      chk("sh_wmask", 32'(dmem_wmask), 32'hC);
      chk("sh_write", 32'(dmem_write), 32'h1);
      chk("sh_wdata", dmem_wdata, 32'hABCD0000);
      chk("sh_stall", 32'(mem_stall), 32'h1);
      chk("sh_addr", dmem_address, 32'h40);
      tick();
    end
    drive(0, 1, 3'b001, 32'h42, 32'hABCD0000, 0, 1, 32'h0);
    chk("sh_resp_write", 32'(dmem_write), 32'h1);
    chk("sh_resp_stall", 32'(mem_stall), 32'h0);
    tick();

    // sw completes under pipe_hold for 4 cycles
    drive(0, 1, 3'b010, 32'h80, 32'h11223344, 1, 1, 32'h0);
    chk("sw_wmask", 32'(dmem_wmask), 32'hF);
    chk("sw_stall", 32'(mem_stall), 32'h0);
    if (dmem_write) wcount++;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 3'b010, 32'h80, 32'h11223344, 1, 0, 32'h0);
      chk("sw_done_stall", 32'(mem_stall), 32'h0);
      chk("sw_done_write", 32'(dmem_write), 32'h0);
      if (dmem_write) wcount++;
      tick();
    end
    drive(0, 1, 3'b010, 32'h80, 32'h11223344, 0, 0, 32'h0);
    chk("sw_release_write", 32'(dmem_write), 32'h0);
    if (dmem_write) wcount++;
    chk("sw_write_count", 32'(wcount), 32'h1);
    tick();

    // next load after release must issue immediately from IDLE
    drive(1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 32'h0);
    chk("post_sw_read", 32'(dmem_read), 32'h1);
    chk("post_sw_stall", 32'(mem_stall), 32'h1);
    tick();

    // lw completes under pipe_hold; rdata bus then goes to 0
    drive(1, 0, 3'b010, 32'h10, 32'h0, 1, 1, 32'h12345678);
    chk("lwh_load", load_data, 32'h12345678);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 3'b010, 32'h10, 32'h0, 1, 0, 32'h0);
      chk("lwh_hold_load", load_data, 32'h12345678);
      chk("lwh_hold_read", 32'(dmem_read), 32'h0);
      chk("lwh_hold_stall", 32'(mem_stall), 32'h0);
      tick();
    end
    drive(1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 32'h0);
    chk("lwh_release_load", load_data, 32'h12345678);
    tick();

    // reset while BUSY
    drive(1, 0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0);
    chk("busy_stall0", 32'(mem_stall), 32'h1);
    tick();
    chk("busy_read", 32'(dmem_read), 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_busy_read", 32'(dmem_read), 32'h0);
    chk("rst_busy_stall", 32'(mem_stall), 32'h0);
    chk("rst_busy_wmask", 32'(dmem_wmask), 32'h0);
    tick();
    rst = 1'b1;
    drive(0, 0, 3'b010, 32'h300, 32'h0, 0, 1, 32'hFFFFFFFF);
    chk("stray_load", load_data, 32'h0);
    chk("stray_read", 32'(dmem_read), 32'h0);
    chk("stray_stall", 32'(mem_stall), 32'h0);
    tick();
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0);
    chk("stray_loadq", load_data, 32'h0);
    tick();

    // misaligned sh at offset 3 after reset: issues from IDLE
    drive(0, 1, 3'b001, 32'h3, 32'h0, 0, 0, 32'h0);
    chk("sh3_wmask", 32'(dmem_wmask), 32'h8);
    chk("sh3_addr", dmem_address, 32'h0);
    chk("sh3_write", 32'(dmem_write), 32'h1);
    chk("sh3_stall", 32'(mem_stall), 32'h1);
    tick();
    drive(0, 1, 3'b001, 32'h3, 32'h0, 0, 1, 32'h0);
    chk("sh3_resp_stall", 32'(mem_stall), 32'h0);
    tick();
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
